// File: rtl/seg7_pkg.sv
// Shared types and segment patterns for the seven-segment scan driver.
// Bit order of every pattern is {g,f,e,d,c,b,a}, active-high.
package seg7_pkg;

    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG_BLANK = 7'b0000000;

    localparam seg7_t SEG_0 = 7'b0111111;
    localparam seg7_t SEG_1 = 7'b0000110;
    localparam seg7_t SEG_2 = 7'b1011011;
    localparam seg7_t SEG_3 = 7'b1001111;
    localparam seg7_t SEG_4 = 7'b1100110;
    localparam seg7_t SEG_5 = 7'b1101101;
    localparam seg7_t SEG_6 = 7'b1111101;
    localparam seg7_t SEG_7 = 7'b0000111;
    localparam seg7_t SEG_8 = 7'b1111111;
    localparam seg7_t SEG_9 = 7'b1101111;

    localparam seg7_t SEG_A = 7'b1110111;
    localparam seg7_t SEG_B = 7'b1111100;
    localparam seg7_t SEG_C = 7'b0111001;
    localparam seg7_t SEG_D = 7'b1011110;
    localparam seg7_t SEG_E = 7'b1111001;
    localparam seg7_t SEG_F = 7'b1110001;

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble-to-segment decoder. In BCD mode the codes 10..15
// render dark; in hex mode they render A, b, C, d, E, F. A blank request
// overrides the nibble entirely.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] i_nibble,
    input  logic       i_hex_mode,
    input  logic       i_blank,
    output seg7_t      o_seg
);

    // Map the nibble to its segment pattern, blank first so it always wins
    always_comb begin
        o_seg = SEG_BLANK;
        if (!i_blank) begin
            case (i_nibble)
                4'h0:    o_seg = SEG_0;
                4'h1:    o_seg = SEG_1;
                4'h2:    o_seg = SEG_2;
                4'h3:    o_seg = SEG_3;
                4'h4:    o_seg = SEG_4;
                4'h5:    o_seg = SEG_5;
                4'h6:    o_seg = SEG_6;
                4'h7:    o_seg = SEG_7;
                4'h8:    o_seg = SEG_8;
                4'h9:    o_seg = SEG_9;
                4'hA:    o_seg = i_hex_mode ? SEG_A : SEG_BLANK;
                4'hB:    o_seg = i_hex_mode ? SEG_B : SEG_BLANK;
                4'hC:    o_seg = i_hex_mode ? SEG_C : SEG_BLANK;
                4'hD:    o_seg = i_hex_mode ? SEG_D : SEG_BLANK;
                4'hE:    o_seg = i_hex_mode ? SEG_E : SEG_BLANK;
                default: o_seg = i_hex_mode ? SEG_F : SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit seven-segment driver.
// A refresh counter steps the scan index one digit per 2**DIV_WIDTH cycles.
// New digit values land in a staging register and are copied to the
// display register only at a frame boundary, so a frame never shows a mix
// of old and new digits. Outputs are registered from (idx, display).
// Optional build macro SEG7_BRIGHTNESS_EN adds a brightness input that
// lights segments/dp only while refresh_cnt <= brightness within a slot.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 2,
    parameter int DIV_WIDTH  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    input  logic                    hex_mode,
    input  logic                    blank_lz,
`ifdef SEG7_BRIGHTNESS_EN
    input  logic [DIV_WIDTH-1:0]    brightness,
`endif
    output logic [6:0]              seg_out,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   dig_sel,
    output logic                    frame_done
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    logic [DIV_WIDTH-1:0]    r_refresh_cnt;
    logic [IDX_W-1:0]        r_idx;
    logic [4*NUM_DIGITS-1:0] r_staging_dig;
    logic [NUM_DIGITS-1:0]   r_staging_dp;
    logic [4*NUM_DIGITS-1:0] r_display_dig;
    logic [NUM_DIGITS-1:0]   r_display_dp;
    logic                    r_pending;
    logic [6:0]              r_seg;
    logic                    r_dp;
    logic [NUM_DIGITS-1:0]   r_dig_sel;
    logic                    r_frame_done;

    logic                    w_tick;
    logic                    w_boundary;
    logic [3:0]              w_nibble;
    logic                    w_dp_sel;
    logic [NUM_DIGITS-1:0]   w_lz_zero;
    logic                    w_blank;
    logic                    w_lit;
    seg7_t                   w_seg;

    assign w_tick     = enable && (r_refresh_cnt == '1);
    assign w_boundary = w_tick && (r_idx == LAST_IDX);
    assign w_nibble   = r_display_dig[{r_idx, 2'b00} +: 4];
    assign w_dp_sel   = r_display_dp[r_idx];

`ifdef SEG7_BRIGHTNESS_EN
    assign w_lit = (r_refresh_cnt <= brightness);
`else
    assign w_lit = 1'b1;
`endif

    // Refresh counter and scan index; both freeze while disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_refresh_cnt <= '0;
            r_idx         <= '0;
        end else if (enable) begin
            r_refresh_cnt <= r_refresh_cnt + 1'b1;
            if (w_tick) begin
                r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1);
            end
        end
    end

    // Staging/display handshake: commit only at a frame boundary, and a
    // load on the boundary cycle goes to staging for the next frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_staging_dig <= '0;
            r_staging_dp  <= '0;
            r_display_dig <= '0;
            r_display_dp  <= '0;
            r_pending     <= 1'b0;
        end else begin
            if (w_boundary && r_pending) begin
                r_display_dig <= r_staging_dig;
                r_display_dp  <= r_staging_dp;
            end
            if (load) begin
                r_staging_dig <= digits_in;
                r_staging_dp  <= dp_in;
                r_pending     <= 1'b1;
            end else if (w_boundary) begin
                r_pending     <= 1'b0;
            end
        end
    end

    // Leading-zero map: bit k set when nibble k and every higher nibble is 0
    always_comb begin
        logic zero_run;
        zero_run  = 1'b1;
        w_lz_zero = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_run     = zero_run && (r_display_dig[4*k +: 4] == 4'h0);
            w_lz_zero[k] = zero_run;
        end
    end

    assign w_blank = blank_lz && w_lz_zero[r_idx] && (r_idx != '0);

    seg7_decode u_decode (
        .i_nibble   (w_nibble),
        .i_hex_mode (hex_mode),
        .i_blank    (w_blank),
        .o_seg      (w_seg)
    );

    // Output register: dark while disabled, otherwise the selected digit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg        <= '0;
            r_dp         <= 1'b0;
            r_dig_sel    <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_boundary;
            if (!enable) begin
                r_seg     <= '0;
                r_dp      <= 1'b0;
                r_dig_sel <= '0;
            end else begin
                r_seg     <= w_lit ? w_seg : SEG_BLANK;
                r_dp      <= w_lit && w_dp_sel;
                r_dig_sel <= NUM_DIGITS'(1) << r_idx;
            end
        end
    end

    assign seg_out    = r_seg;
    assign dp_out     = r_dp;
    assign dig_sel    = r_dig_sel;
    assign frame_done = r_frame_done;

endmodule
